noc_input_port: RTL and testbench
=================================

Name: noc_input_port

Overview:
- Requester-side counterpart of the 5-port round-robin output arbiter in the mesh router.
- Buffers incoming single-flit packets in a FIFO and computes an XY route for the head flit.
- Presents the route as a one-hot 5-bit request to the arbiter and dequeues the flit when granted.
- Drives the dequeued flit, registered, toward the crossbar.

Parameters:
- DATA_W, 64, flit width in bits.
- DEPTH, 4, FIFO depth in flits; power of two, at least 2.
- COORD_W, 2, width of each destination coordinate field.
- MY_X, 0, this router's X coordinate.
- MY_Y, 0, this router's Y coordinate.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_vld  in  1  upstream flit valid.
- in_data  in  DATA_W  upstream flit.
- in_rdy  out  1  FIFO not full, so the port can accept a flit.
- req  out  5  one-hot route request for the head flit; 0 when the FIFO is empty.
- gnt  in  1  arbiter grant to this port, valid in the same cycle as req.
- out_vld  out  1  crossbar flit valid, one cycle after the grant.
- out_data  out  DATA_W  crossbar flit.
- out_dir  out  5  one-hot direction of out_data; equals the req value that was granted.

Behaviour:
- Reset: rst=1 at a clock edge gives:
  - read pointer, write pointer and count = 0;
  - in_rdy=1, req=0, out_vld=0, out_data=0, out_dir=0.
  - Reset asserted mid-transfer discards all buffered flits and any pending out_vld.
- Header fields of the head flit:
  - dest_x = head[DATA_W-1 -: COORD_W];
  - dest_y = head[DATA_W-1-COORD_W -: COORD_W].
  - Comparisons are unsigned.
- Request bit order: req[0]=Local, req[1]=North, req[2]=East, req[3]=South, req[4]=West.
- XY route, evaluated in this order:
  - dest_x > MY_X -> East;
  - dest_x < MY_X -> West;
  - dest_y > MY_Y -> North;
  - dest_y < MY_Y -> South;
  - otherwise Local.
- req is combinational from the FIFO head and count:
  - exactly one bit is set when count > 0;
  - req is 0 when count = 0.
- Enqueue: on in_vld & in_rdy, the flit is written at the write pointer, which then increments modulo DEPTH.
- Full FIFO: in_vld while count = DEPTH is dropped; the FIFO is unchanged and in_rdy stays 0.
- Dequeue: on gnt & (count > 0) at a clock edge:
  - the head is popped and the read pointer increments modulo DEPTH;
  - out_data is loaded with the head flit and out_dir with the current req;
  - out_vld = 1 for the next cycle only.
- gnt with count = 0 is ignored: no pop, and out_vld = 0 next cycle.
- Simultaneous enqueue and dequeue:
  - allowed at any count, including count = DEPTH;
  - at count = DEPTH, in_rdy is still 0, so the write is refused that cycle;
  - count is unchanged when both occur, and pointers wrap independently.
- Latency:
  - a write into an empty FIFO raises req in the following cycle;
  - a grant produces out_vld in the following cycle;
  - minimum in_vld -> out_vld latency is 2 cycles.
- Back-to-back: gnt held high with count ≥ 2 pops one flit per cycle, giving continuous out_vld; req updates each cycle to the new head's route.
- When out_vld = 0, out_data and out_dir hold their last values.

Optional Feature:
- Macro: NOC_INPUT_PORT_DROP_CNT_EN.
- When defined:
  - adds output port drop_cnt, 8 bits;
  - drop_cnt increments on every in_vld while count = DEPTH;
  - it saturates at 255 and resets to 0 on rst.
- When undefined: the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then idle, with MY_X=1, MY_Y=1 -> in_rdy=1, req=5'b00000, out_vld=0.
- Write one flit with dest (2,1) -> req=5'b00100 (East) next cycle; assert gnt -> out_vld=1 with that flit and out_dir=5'b00100 one cycle later; req returns to 0.
- Write four flits with dests (0,1), (1,2), (1,0), (1,1) -> req sequence 5'b10000, 5'b00010, 5'b01000, 5'b00001 as gnt is held for 4 cycles; out_vld high for 4 consecutive cycles.
- Fill 4 flits, then drive in_vld with no gnt -> in_rdy=0, the 5th flit is dropped; drop_cnt=1 when the macro is defined; draining yields exactly the first 4 flits in order.
- With count=2, assert in_vld and gnt in the same cycle for 6 cycles -> count stays 2, pointers wrap, output order matches input order.
- Assert rst with 3 flits queued and gnt high -> next cycle count=0, req=0, out_vld=0, in_rdy=1.

Source files
------------

// File: rtl/noc_input_port.sv
// Mesh router input port: FIFO of single-flit packets, XY route request for the head flit,
// registered dequeue toward the crossbar. Optional drop counter under NOC_INPUT_PORT_DROP_CNT_EN.
module noc_input_port #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 2,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_rdy,
  output logic [4:0]        req,
  input  logic              gnt,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_dir
`ifdef NOC_INPUT_PORT_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
  localparam logic [COORD_W-1:0] MY_X_C   = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY_Y_C   = COORD_W'(MY_Y);

  localparam logic [4:0] DIR_LOCAL = 5'b00001;
  localparam logic [4:0] DIR_NORTH = 5'b00010;
  localparam logic [4:0] DIR_EAST  = 5'b00100;
  localparam logic [4:0] DIR_SOUTH = 5'b01000;
  localparam logic [4:0] DIR_WEST  = 5'b10000;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  head;
  logic [COORD_W-1:0] dest_x;
  logic [COORD_W-1:0] dest_y;
  logic               not_empty;
  logic               push;
  logic               pop;

  assign head      = mem[rd_ptr];
  assign dest_x    = head[DATA_W-1 -: COORD_W];
  assign dest_y    = head[DATA_W-1-COORD_W -: COORD_W];
  assign not_empty = (count != '0);
  assign in_rdy    = (count != FULL_CNT);
  assign push      = in_vld & in_rdy;
  assign pop       = gnt & not_empty;

  // Dimension-order routing: resolve X completely before Y.
  always_comb begin
    req = '0;
    if (not_empty) begin
      if (dest_x > MY_X_C)      req = DIR_EAST;
      else if (dest_x < MY_X_C) req = DIR_WEST;
      else if (dest_y > MY_Y_C) req = DIR_NORTH;
      else if (dest_y < MY_Y_C) req = DIR_SOUTH;
      else                      req = DIR_LOCAL;
    end
  end

  // Storage is not reset; only the pointers and count define valid contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_dir  <= '0;
    end else begin
      out_vld <= pop;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        out_data <= head;
        out_dir  <= req;
      end
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

`ifdef NOC_INPUT_PORT_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (in_vld && !in_rdy && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_input_port.sv
// Directed bench for noc_input_port at router (1,1): table-driven vectors for routing and
// back-to-back grants, plus hand sequences for full/drop, concurrent push/pop and mid-transfer reset.
module tb_noc_input_port;

  localparam int DATA_W  = 64;
  localparam int DEPTH   = 4;
  localparam int COORD_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_vld;
  logic [DATA_W-1:0] in_data;
  logic              in_rdy;
  logic [4:0]        req;
  logic              gnt;
  logic              out_vld;
  logic [DATA_W-1:0] out_data;
  logic [4:0]        out_dir;
`ifdef NOC_INPUT_PORT_DROP_CNT_EN
  logic [7:0]        drop_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  noc_input_port #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .COORD_W(COORD_W), .MY_X(1), .MY_Y(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_vld(in_vld),
    .in_data(in_data),
    .in_rdy(in_rdy),
    .req(req),
    .gnt(gnt),
    .out_vld(out_vld),
    .out_data(out_data),
    .out_dir(out_dir)
`ifdef NOC_INPUT_PORT_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [4:0] L = 5'b00001;
  localparam logic [4:0] N = 5'b00010;
  localparam logic [4:0] E = 5'b00100;
  localparam logic [4:0] S = 5'b01000;
  localparam logic [4:0] W = 5'b10000;

  typedef struct {
    logic              in_vld;
    logic [DATA_W-1:0] in_data;
    logic              gnt;
    logic              exp_rdy;
    logic [4:0]        exp_req;
    logic              exp_vld;
    logic [DATA_W-1:0] exp_data;
    logic [4:0]        exp_dir;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [DATA_W-1:0] flit(input int x, input int y, input int tag);
    logic [1:0] xx;
    logic [1:0] yy;
    logic [7:0] tt;
    xx = x[1:0];
    yy = y[1:0];
    tt = tag[7:0];
    return {xx, yy, 52'h0, tt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [DATA_W-1:0] d, input logic g);
    in_vld  = v;
    in_data = d;
    gnt     = g;
  endtask

  task automatic check_output(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [DATA_W-1:0] d, input logic [4:0] dir);
    check_output({name, " out_vld"}, {63'h0, out_vld}, 64'h1);
    check_output({name, " out_data"}, out_data, d);
    check_output({name, " out_dir"}, {59'h0, out_dir}, {59'h0, dir});
  endtask

  logic [DATA_W-1:0] g[4];
  logic [4:0]        g_dir[4];
  logic [DATA_W-1:0] h[8];
  logic [4:0]        h_dir[8];

  initial begin
    logic [DATA_W-1:0] f1, f2, f3, f4, f5;
    f1 = flit(2, 1, 1);
    f2 = flit(0, 1, 2);
    f3 = flit(1, 2, 3);
    f4 = flit(1, 0, 4);
    f5 = flit(1, 1, 5);

    // Each row: outputs expected now, then inputs driven for the coming edge.
    vecs[0]  = '{1'b1, f1,   1'b0, 1'b1, 5'b0, 1'b0, 64'h0, 5'b0};
    vecs[1]  = '{1'b0, 64'h0, 1'b1, 1'b1, E,   1'b0, 64'h0, 5'b0};
    vecs[2]  = '{1'b0, 64'h0, 1'b0, 1'b1, 5'b0, 1'b1, f1,   E};
    vecs[3]  = '{1'b1, f2,   1'b0, 1'b1, 5'b0, 1'b0, f1,   E};
    vecs[4]  = '{1'b1, f3,   1'b0, 1'b1, W,   1'b0, f1,   E};
    vecs[5]  = '{1'b1, f4,   1'b0, 1'b1, W,   1'b0, f1,   E};
    vecs[6]  = '{1'b1, f5,   1'b0, 1'b1, W,   1'b0, f1,   E};
    vecs[7]  = '{1'b0, 64'h0, 1'b1, 1'b0, W,   1'b0, f1,   E};
    vecs[8]  = '{1'b0, 64'h0, 1'b1, 1'b1, N,   1'b1, f2,   W};
    vecs[9]  = '{1'b0, 64'h0, 1'b1, 1'b1, S,   1'b1, f3,   N};
    vecs[10] = '{1'b0, 64'h0, 1'b1, 1'b1, L,   1'b1, f4,   S};
    vecs[11] = '{1'b0, 64'h0, 1'b1, 1'b1, 5'b0, 1'b1, f5,   L};
    vecs[12] = '{1'b0, 64'h0, 1'b0, 1'b1, 5'b0, 1'b0, f5,   L};
    vecs[13] = '{1'b0, 64'h0, 1'b0, 1'b1, 5'b0, 1'b0, f5,   L};

    g[0] = flit(3, 0, 16'h10); g_dir[0] = E;
    g[1] = flit(1, 3, 16'h11); g_dir[1] = N;
    g[2] = flit(0, 0, 16'h12); g_dir[2] = W;
    g[3] = flit(1, 0, 16'h13); g_dir[3] = S;

    h[0] = flit(2, 1, 16'h20); h_dir[0] = E;
    h[1] = flit(0, 0, 16'h21); h_dir[1] = W;
    h[2] = flit(1, 2, 16'h22); h_dir[2] = N;
    h[3] = flit(1, 0, 16'h23); h_dir[3] = S;
    h[4] = flit(1, 1, 16'h24); h_dir[4] = L;
    h[5] = flit(3, 3, 16'h25); h_dir[5] = E;
    h[6] = flit(0, 3, 16'h26); h_dir[6] = W;
    h[7] = flit(1, 3, 16'h27); h_dir[7] = N;

    rst = 1'b1;
    apply_stimulus(1'b0, '0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    check_output("reset in_rdy", {63'h0, in_rdy}, 64'h1);
    check_output("reset req", {59'h0, req}, 64'h0);
    check_output("reset out_vld", {63'h0, out_vld}, 64'h0);
    check_output("reset out_data", out_data, 64'h0);
    check_output("reset out_dir", {59'h0, out_dir}, 64'h0);
`ifdef NOC_INPUT_PORT_DROP_CNT_EN
    check_output("reset drop_cnt", {56'h0, drop_cnt}, 64'h0);
`endif

    for (int i = 0; i < 14; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      check_output({tag, " in_rdy"}, {63'h0, in_rdy}, {63'h0, vecs[i].exp_rdy});
      check_output({tag, " req"}, {59'h0, req}, {59'h0, vecs[i].exp_req});
      check_output({tag, " out_vld"}, {63'h0, out_vld}, {63'h0, vecs[i].exp_vld});
      check_output({tag, " out_data"}, out_data, vecs[i].exp_data);
      check_output({tag, " out_dir"}, {59'h0, out_dir}, {59'h0, vecs[i].exp_dir});
      apply_stimulus(vecs[i].in_vld, vecs[i].in_data, vecs[i].gnt);
      tick();
    end

    // Fill to DEPTH, offer a fifth flit that must be dropped, then drain.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, g[i], 1'b0);
      tick();
    end
    check_output("full in_rdy", {63'h0, in_rdy}, 64'h0);
    check_output("full req", {59'h0, req}, {59'h0, g_dir[0]});
    apply_stimulus(1'b1, flit(2, 2, 16'h1F), 1'b0);
    tick();
    check_output("drop in_rdy", {63'h0, in_rdy}, 64'h0);
    check_output("drop out_vld", {63'h0, out_vld}, 64'h0);
`ifdef NOC_INPUT_PORT_DROP_CNT_EN
    check_output("drop_cnt", {56'h0, drop_cnt}, 64'h1);
`endif
    apply_stimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("drain%0d", i), g[i], g_dir[i]);
    end
    apply_stimulus(1'b0, '0, 1'b0);
    tick();
    check_output("drained out_vld", {63'h0, out_vld}, 64'h0);
    check_output("drained req", {59'h0, req}, 64'h0);
    check_output("drained in_rdy", {63'h0, in_rdy}, 64'h1);

    // Concurrent push and pop at count=2 keeps occupancy constant across pointer wrap.
    apply_stimulus(1'b1, h[0], 1'b0);
    tick();
    apply_stimulus(1'b1, h[1], 1'b0);
    tick();
    check_output("pp start req", {59'h0, req}, {59'h0, h_dir[0]});
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(1'b1, h[k+2], 1'b1);
      tick();
      check_out($sformatf("pp%0d", k), h[k], h_dir[k]);
      check_output($sformatf("pp%0d in_rdy", k), {63'h0, in_rdy}, 64'h1);
    end
    check_output("pp end req", {59'h0, req}, {59'h0, h_dir[6]});
    apply_stimulus(1'b0, '0, 1'b1);
    tick();
    check_out("pp tail0", h[6], h_dir[6]);
    tick();
    check_out("pp tail1", h[7], h_dir[7]);
    apply_stimulus(1'b0, '0, 1'b0);
    tick();
    check_output("pp empty out_vld", {63'h0, out_vld}, 64'h0);
    check_output("pp empty req", {59'h0, req}, 64'h0);

    // Reset with flits queued and a grant pending must discard everything.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, g[i], 1'b0);
      tick();
    end
    check_output("pre-rst req", {59'h0, req}, {59'h0, g_dir[0]});
    apply_stimulus(1'b0, '0, 1'b1);
    rst = 1'b1;
    tick();
    check_output("rst req", {59'h0, req}, 64'h0);
    check_output("rst out_vld", {63'h0, out_vld}, 64'h0);
    check_output("rst in_rdy", {63'h0, in_rdy}, 64'h1);
    check_output("rst out_data", out_data, 64'h0);
    check_output("rst out_dir", {59'h0, out_dir}, 64'h0);
    rst = 1'b0;
    apply_stimulus(1'b0, '0, 1'b0);
    tick();
    check_output("post-rst req", {59'h0, req}, 64'h0);
    check_output("post-rst out_vld", {63'h0, out_vld}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
